// File: rtl/bram_line_reader.sv
// Reads a run of 32-bit words from the scanline RAM and streams them out as
// four 8-bit pixels each (low byte first) over a ready/valid handshake.
module bram_line_reader (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  base_addr,
    input  logic [8:0]  word_count,
    output logic        ram_en,
    output logic [8:0]  ram_addr,
    input  logic [31:0] ram_data,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [9:0]       rem_q, rem_d;
    logic [8:0]       addr_q, addr_d;
    logic             ren_q, ren_d;
    logic             vpipe_q, vpipe_d;
    logic [1:0][31:0] fifo_q, fifo_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [31:0]      sh_q, sh_d;
    logic [1:0]       idx_q, idx_d;
    logic             pv_q, pv_d;
    logic             done_q, done_d;

    logic       accept;
    logic       load;
    logic       last_pix;
    logic [2:0] occ;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        ren_d    = 1'b0;
        vpipe_d  = ren_q;
        fifo_d   = fifo_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        sh_d     = sh_q;
        idx_d    = idx_q;
        pv_d     = pv_q;
        done_d   = 1'b0;

        accept   = pv_q && pix_ready;
        // Buffered words plus reads still travelling through the RAM pipeline.
        occ      = {1'b0, fcnt_q} + {2'b00, ren_q} + {2'b00, vpipe_q};
        load     = (fcnt_q != 2'd0) && (!pv_q || (accept && idx_q == 2'd3));
        last_pix = (state_q == S_DRAIN) && accept && (idx_q == 2'd3)
                   && (fcnt_q == 2'd0) && !ren_q && !vpipe_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count == 9'd0) begin
                        done_d = 1'b1;
                    end else begin
                        ren_d   = 1'b1;
                        addr_d  = base_addr;
                        rem_d   = {1'b0, word_count} - 10'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (rem_q == 10'd0) begin
                    state_d = S_DRAIN;
                end else if (occ < 3'd2) begin
                    ren_d  = 1'b1;
                    addr_d = addr_q + 9'd1;
                    rem_d  = rem_q - 10'd1;
                end
            end
            S_DRAIN: begin
                if (last_pix) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (vpipe_q) begin
            fifo_d[wptr_q] = ram_data;
            wptr_d         = ~wptr_q;
        end
        if (load) begin
            rptr_d = ~rptr_q;
        end
        fcnt_d = fcnt_q + {1'b0, vpipe_q} - {1'b0, load};

        if (load) begin
            sh_d  = fifo_q[rptr_q];
            idx_d = 2'd0;
            pv_d  = 1'b1;
        end else if (accept) begin
            sh_d  = {8'h00, sh_q[31:8]};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                pv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            vpipe_q <= 1'b0;
            fifo_q  <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            fcnt_q  <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            ren_q   <= ren_d;
            vpipe_q <= vpipe_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
        end
    end

    assign ram_en    = ren_q;
    assign ram_addr  = addr_q;
    assign pix_data  = sh_q[7:0];
    assign pix_valid = pv_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) || done_q;

endmodule
